// File: rtl/mac_window_ctrl.sv
// Purpose : sequences one 3x3 tap window: buffer read -> multiplier -> accumulator strobe, then offers the sum.
// Latency : start sampled at edge 0; rd_en cycles 1..TAPS; res_valid rises in cycle 12+MUL_LAT.
// Backpr. : result held stable in RESULT until res_ready; start is ignored (not queued) while busy.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset shared with the accumulator
//   start             window request, sampled only in IDLE
//   busy              high in every state except IDLE
//   rd_en, rd_addr    operand buffer read strobe and tap address 0..TAPS-1 (data returns 1 cycle later)
//   acc_valid         accumulator strobe, aligned with the multiplier product
//   acc_out           accumulator register value
//   res_valid/ready   result handshake; res_data is the captured window sum
// Optional feature (macro WIN_CNT_EN): adds output win_cnt[15:0], counting accepted results (wraps).
// TAPS must be 9: the accumulator reloads itself every 9 strobes.
module mac_window_ctrl #(
    parameter int TAPS    = 9,
    parameter int MUL_LAT = 1,
    parameter int AW      = 4,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          acc_valid,
    input  logic [DW-1:0] acc_out,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    input  logic          res_ready
`ifdef WIN_CNT_EN
    ,
    output logic [15:0]   win_cnt
`endif
);

    // One cycle of buffer read latency plus the multiplier pipeline.
    localparam int DLY = 1 + MUL_LAT;
    // Delay-line pattern seen in the cycle of the final strobe: only the tail bit set.
    localparam logic [DLY-1:0] DLY_LAST = DLY'(1) << (DLY - 1);
    localparam logic [AW-1:0]  ADDR_LAST = AW'(TAPS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        CAPT   = 3'd3,
        RESULT = 3'd4
    } state_t;

    state_t         state;
    logic [DLY-1:0] vld_sr;

    // acc_valid is purely rd_en delayed, so the strobe count always equals the read count.
    assign acc_valid = vld_sr[DLY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | DLY'(rd_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                ISSUE: begin
                    if (rd_addr == ADDR_LAST) begin
                        state   <= DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Leave after the last strobe so the accumulator register has updated in CAPT.
                    if (vld_sr == DLY_LAST) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    res_data  <= acc_out;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rd_en     <= 1'b0;
                    rd_addr   <= '0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef WIN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (res_valid && res_ready) begin
            win_cnt <= win_cnt + 16'd1;
        end
    end
`endif

endmodule
